// File: rtl/usb_ccw_rx.sv
// usb_ccw_rx: receive-side CCW framer on the FTDI clock domain.
// Frame format: SYNC_BYTE, PAYLOAD_BYTES payload bytes, then one XOR checksum byte.
// A frame whose checksum matches is written to the CCW buffer. A bad checksum
// or an inter-byte stall raises an error pulse and the framer goes back to
// hunting for the next sync byte.
module usb_ccw_rx #(
  parameter int         PAYLOAD_BYTES = 8,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         TIMEOUT_CYC   = 1024
) (
  input  logic                       clk_ftdi,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_rdy,
  input  logic                       ccwb_full,
  output logic                       ccwb_wrreq,
  output logic [8*PAYLOAD_BYTES-1:0] ccwb_data,
  output logic                       ccw_accepted,
  output logic                       ccw_err,
  output logic                       ccw_timeout,
  output logic [7:0]                 err_cnt
);

  localparam int DATA_W = 8 * PAYLOAD_BYTES;
  localparam int CNT_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_PAYLOAD,
    ST_CSUM,
    ST_WRITE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [DATA_W-1:0]   payload_sr;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    byte_cnt;
  logic [7:0]          xor_acc;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                xfer;
  logic                is_sync;
  logic                last_byte;
  logic                csum_ok;
  logic                in_frame;
  logic                tmo_hit;
  logic                commit;

  assign xfer      = rx_valid & rx_rdy;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign last_byte = (byte_cnt == CNT_W'(PAYLOAD_BYTES - 1));
  assign csum_ok   = (rx_data == xor_acc);
  assign in_frame  = (state == ST_PAYLOAD) || (state == ST_CSUM);
  // A byte arriving in the last allowed cycle beats the timeout.
  assign tmo_hit   = in_frame && !xfer && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk_ftdi or posedge rst) begin
    if (rst) state <= ST_HUNT;
    else     state <= next_state;
  end

  // Next-state logic: hunt for sync, collect payload, check sum, commit.
  always_comb begin
    next_state = state;
    case (state)
      ST_HUNT: begin
        if (xfer && is_sync) next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (xfer && last_byte) next_state = ST_CSUM;
        else if (tmo_hit)      next_state = ST_HUNT;
      end
      ST_CSUM: begin
        if (xfer)         next_state = csum_ok ? ST_WRITE : ST_HUNT;
        else if (tmo_hit) next_state = ST_HUNT;
      end
      ST_WRITE: begin
        if (!ccwb_full) next_state = ST_HUNT;
      end
      default: next_state = ST_HUNT;
    endcase
  end

  // Output logic: the commit cycle shows the new word; otherwise the last written word is held.
  always_comb begin
    commit       = (state == ST_WRITE) && !ccwb_full;
    ccwb_wrreq   = commit;
    ccw_accepted = commit;
    ccwb_data    = commit ? payload_sr : data_q;
  end

  // Ready is low only while a completed word waits for buffer space.
  always_ff @(posedge clk_ftdi or posedge rst) begin
    if (rst) rx_rdy <= 1'b0;
    else     rx_rdy <= (next_state != ST_WRITE);
  end

  // Frame datapath: payload shift register, byte count, running XOR and stall counter.
  always_ff @(posedge clk_ftdi or posedge rst) begin
    if (rst) begin
      payload_sr <= '0;
      byte_cnt   <= '0;
      xor_acc    <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (xfer && is_sync) begin
            byte_cnt <= '0;
            xor_acc  <= '0;
            tmo_cnt  <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            payload_sr <= {payload_sr[DATA_W-9:0], rx_data};
            xor_acc    <= xor_acc ^ rx_data;
            byte_cnt   <= byte_cnt + CNT_W'(1);
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_CSUM: begin
          if (xfer) tmo_cnt <= '0;
          else      tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Error and timeout pulses, and the saturating event counter fed by them.
  always_ff @(posedge clk_ftdi or posedge rst) begin
    if (rst) begin
      ccw_err     <= 1'b0;
      ccw_timeout <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      ccw_err     <= (state == ST_CSUM) && xfer && !csum_ok;
      ccw_timeout <= tmo_hit;
      if ((ccw_err || ccw_timeout) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Held copy of the last committed word, updated only when the buffer takes it.
  always_ff @(posedge clk_ftdi or posedge rst) begin
    if (rst)         data_q <= '0;
    else if (commit) data_q <= payload_sr;
  end

endmodule
